// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: a DEPTH-entry shift scoreboard of in-flight register writes
// behind decode, producing per-source forwarding, a decode stall and a stall counter.
module hazard_scoreboard #(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [RA_W-1:0]       id_rs1_i,
    input  logic [RA_W-1:0]       id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  id_we_i,
    input  logic [RA_W-1:0]       id_rd_i,
    input  logic                  id_is_load_i,
    input  logic                  flush_i,
    input  logic [DEPTH*XLEN-1:0] stage_data_i,
    output logic                  stall_o,
    output logic                  fwd_hit_a_o,
    output logic                  fwd_hit_b_o,
    output logic [IDX_W-1:0]      fwd_idx_a_o,
    output logic [IDX_W-1:0]      fwd_idx_b_o,
    output logic [XLEN-1:0]       fwd_data_a_o,
    output logic [XLEN-1:0]       fwd_data_b_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0]           we_q, we_d;
    logic [DEPTH-1:0]           load_q, load_d;
    logic [DEPTH-1:0][RA_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic [DEPTH-1:0] ready;
    logic [XLEN-1:0]  sdata [DEPTH];
    logic [RA_W-1:0]  src_rs [2];
    logic [1:0]       src_used;
    logic             push;

    assign src_rs[0]   = id_rs1_i;
    assign src_rs[1]   = id_rs2_i;
    assign src_used[0] = id_rs1_used_i;
    assign src_used[1] = id_rs2_used_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign ready[gi] = !load_q[gi] || (gi >= LOAD_READY);
        assign sdata[gi] = stage_data_i[gi*XLEN +: XLEN];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [DEPTH-1:0] match;
        logic             found;
        logic [IDX_W-1:0] win;
        logic             hit_l;
        logic             hazard_l;
        logic [IDX_W-1:0] idx_l;
        logic [XLEN-1:0]  data_l;

        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_match
            assign match[gj] = valid_q[gj] && we_q[gj] && (rd_q[gj] == src_rs[gi])
                               && (src_rs[gi] != '0);
        end

        // Scan oldest to youngest so the lowest matching index is left as the winner.
        always_comb begin
            found    = 1'b0;
            win      = '0;
            hit_l    = 1'b0;
            hazard_l = 1'b0;
            idx_l    = '0;
            data_l   = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (match[i]) begin
                    found = 1'b1;
                    win   = IDX_W'(i);
                end
            end
            if (id_valid_i && src_used[gi] && found) begin
                if (ready[win]) begin
                    hit_l  = 1'b1;
                    idx_l  = win;
                    data_l = sdata[win];
                end else begin
                    hazard_l = 1'b1;
                end
            end
        end
    end

    assign stall_o      = id_valid_i && !flush_i && (g_src[0].hazard_l || g_src[1].hazard_l);
    assign fwd_hit_a_o  = g_src[0].hit_l;
    assign fwd_hit_b_o  = g_src[1].hit_l;
    assign fwd_idx_a_o  = g_src[0].idx_l;
    assign fwd_idx_b_o  = g_src[1].idx_l;
    assign fwd_data_a_o = g_src[0].data_l;
    assign fwd_data_b_o = g_src[1].data_l;
    assign stall_cnt_o  = cnt_q;

    // A stalled or flushed decode slot enters the pipe as a bubble.
    assign push = id_valid_i && !stall_o && !flush_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
        if (gi == 0) begin : g_head
            assign valid_d[gi] = push;
            assign we_d[gi]    = id_we_i;
            assign rd_d[gi]    = id_rd_i;
            assign load_d[gi]  = id_is_load_i;
        end else begin : g_body
            assign valid_d[gi] = valid_q[gi-1];
            assign we_d[gi]    = we_q[gi-1];
            assign rd_d[gi]    = rd_q[gi-1];
            assign load_d[gi]  = load_q[gi-1];
        end
    end

    assign cnt_d = (stall_o && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            we_q    <= '0;
            load_q  <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3, LOAD_READY=2, CNT_W=4); expected
// outputs are queued by the driver and compared by a monitor on the falling edge.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] sd0, sd1, sd2;
    logic [95:0] stage_data;
    logic        stall, fwd_hit_a, fwd_hit_b;
    logic [1:0]  fwd_idx_a, fwd_idx_b;
    logic [31:0] fwd_data_a, fwd_data_b;
    logic [3:0]  stall_cnt;

    assign stage_data = {sd2, sd1, sd0};

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .XLEN(32), .RA_W(5), .DEPTH(3), .LOAD_READY(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_we_i(id_we), .id_rd_i(id_rd), .id_is_load_i(id_is_load),
        .flush_i(flush), .stage_data_i(stage_data),
        .stall_o(stall), .fwd_hit_a_o(fwd_hit_a), .fwd_hit_b_o(fwd_hit_b),
        .fwd_idx_a_o(fwd_idx_a), .fwd_idx_b_o(fwd_idx_b),
        .fwd_data_a_o(fwd_data_a), .fwd_data_b_o(fwd_data_b),
        .stall_cnt_o(stall_cnt)
    );

    typedef struct packed {
        logic        stall;
        logic        ha;
        logic [1:0]  ia;
        logic [31:0] da;
        logic        hb;
        logic [1:0]  ib;
        logic [31:0] db;
        logic [3:0]  cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    exp_t  mon_e, mon_a;
    string mon_n;
    int    ecnt;

    task automatic expect_out(input string nm, input int st, input int ha, input int ia,
                              input int da, input int hb, input int ib, input int db,
                              input int cnt);
        exp_t e;
        e.stall = 1'(st);
        e.ha    = 1'(ha);
        e.ia    = 2'(ia);
        e.da    = 32'(da);
        e.hb    = 1'(hb);
        e.ib    = 2'(ib);
        e.db    = 32'(db);
        e.cnt   = 4'(cnt);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                         input int we, input int rd, input int ld, input int fl);
        id_valid    = 1'(v);
        id_rs1      = 5'(rs1);
        id_rs1_used = 1'(u1);
        id_rs2      = 5'(rs2);
        id_rs2_used = 1'(u2);
        id_we       = 1'(we);
        id_rd       = 5'(rd);
        id_is_load  = 1'(ld);
        flush       = 1'(fl);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    // Monitor: every falling edge, compare all pending expectations against the DUT.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                mon_a = {stall, fwd_hit_a, fwd_idx_a, fwd_data_a,
                         fwd_hit_b, fwd_idx_b, fwd_data_b, stall_cnt};
                checks++;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL %s: got stall=%0b hitA=%0b idxA=%0d dataA=%h hitB=%0b idxB=%0d dataB=%h cnt=%0d; expected stall=%0b hitA=%0b idxA=%0d dataA=%h hitB=%0b idxB=%0d dataB=%h cnt=%0d",
                             mon_n, mon_a.stall, mon_a.ha, mon_a.ia, mon_a.da, mon_a.hb,
                             mon_a.ib, mon_a.db, mon_a.cnt, mon_e.stall, mon_e.ha, mon_e.ia,
                             mon_e.da, mon_e.hb, mon_e.ib, mon_e.db, mon_e.cnt);
                end else begin
                    $display("check %s ok: stall=%0b hitA=%0b idxA=%0d dataA=%h hitB=%0b idxB=%0d cnt=%0d",
                             mon_n, mon_a.stall, mon_a.ha, mon_a.ia, mon_a.da, mon_a.hb,
                             mon_a.ib, mon_a.cnt);
                end
            end
        end
    end

    initial begin
        // Reset with a dependent-looking instruction in decode: everything must read zero.
        rst_n = 1'b0;
        sd0 = 32'h0000_0010; sd1 = 32'h1111_1111; sd2 = 32'h2222_2222;
        drive(1, 7, 1, 7, 1, 1, 8, 0, 0);
        #2;
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back ALU dependence and forwarding from entry 1.
        step(); drive(1, 0, 1, 0, 0, 1, 5, 0, 0);
        expect_out("alu_prod", 0, 0, 0, 0, 0, 0, 0, 0);
        step(); drive(1, 5, 1, 5, 1, 1, 6, 0, 0);
        expect_out("alu_b2b", 0, 1, 0, 32'h0000_0010, 1, 0, 32'h0000_0010, 0);
        step(); sd0 = 32'h0000_0066; sd1 = 32'h0000_0055;
        drive(1, 5, 1, 6, 1, 0, 0, 0, 0);
        expect_out("alu_dist", 0, 1, 1, 32'h0000_0055, 1, 0, 32'h0000_0066, 0);
        idle(4);

        // Load-use: two stall cycles, then forward from entry 2.
        step(); sd2 = 32'hDEAD_BEEF;
        drive(1, 1, 1, 0, 0, 1, 7, 1, 0);
        expect_out("ld_issue", 0, 0, 0, 0, 0, 0, 0, 0);
        step(); drive(1, 7, 1, 0, 1, 1, 8, 0, 0);
        expect_out("ldu_stall1", 1, 0, 0, 0, 0, 0, 0, 0);
        step(); expect_out("ldu_stall2", 1, 0, 0, 0, 0, 0, 0, 1);
        step(); expect_out("ldu_fwd", 0, 1, 2, 32'hDEAD_BEEF, 0, 0, 0, 2);
        idle(4);

        // Youngest writer wins.
        step(); drive(1, 0, 1, 0, 0, 1, 9, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); drive(1, 0, 1, 0, 0, 1, 9, 0, 0);
        step(); sd0 = 32'hAAAA_AAAA; sd2 = 32'h5555_5555;
        drive(1, 9, 1, 9, 1, 1, 10, 0, 0);
        expect_out("young_fwd", 0, 1, 0, 32'hAAAA_AAAA, 1, 0, 32'hAAAA_AAAA, 2);
        idle(4);

        // Youngest writer is a not-ready load: stall, no fallback to entry 2.
        step(); drive(1, 0, 1, 0, 0, 1, 9, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); drive(1, 1, 1, 0, 0, 1, 9, 1, 0);
        step(); drive(1, 9, 1, 0, 0, 1, 11, 0, 0);
        expect_out("young_ld_stall", 1, 0, 0, 0, 0, 0, 0, 2);
        idle(4);

        // x0 never matches; an unused source never stalls.
        step(); drive(1, 0, 1, 0, 0, 1, 0, 0, 0);
        step(); drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
        expect_out("x0_src", 0, 0, 0, 0, 0, 0, 0, 3);
        step(); drive(1, 1, 1, 0, 0, 1, 3, 1, 0);
        step(); drive(1, 4, 1, 3, 0, 0, 0, 0, 0);
        expect_out("unused_rs2", 0, 0, 0, 0, 0, 0, 0, 3);
        idle(4);

        // Flush beats the stall; the load keeps moving down the pipe.
        step(); sd2 = 32'hCAFE_F00D;
        drive(1, 1, 1, 0, 0, 1, 7, 1, 0);
        step(); drive(1, 7, 1, 0, 0, 1, 8, 0, 1);
        expect_out("flush_win", 0, 0, 0, 0, 0, 0, 0, 3);
        step(); drive(1, 7, 1, 0, 0, 1, 8, 0, 0);
        expect_out("flush_after", 1, 0, 0, 0, 0, 0, 0, 3);
        step(); expect_out("flush_fwd", 0, 1, 2, 32'hCAFE_F00D, 0, 0, 0, 4);
        idle(4);

        // Twenty more stall cycles drive the 4-bit counter into saturation.
        ecnt = 4;
        for (int k = 0; k < 10; k++) begin
            step(); sd2 = 32'h1000_0000 + k;
            drive(1, 1, 1, 0, 0, 1, 7, 1, 0);
            step(); drive(1, 7, 1, 0, 1, 1, 8, 0, 0);
            expect_out("sat_stall_a", 1, 0, 0, 0, 0, 0, 0, ecnt);
            ecnt = (ecnt == 15) ? 15 : ecnt + 1;
            step(); expect_out("sat_stall_b", 1, 0, 0, 0, 0, 0, 0, ecnt);
            ecnt = (ecnt == 15) ? 15 : ecnt + 1;
            step(); expect_out("sat_fwd", 0, 1, 2, 32'h1000_0000 + k, 0, 0, 0, ecnt);
        end

        // Stall while saturated, then reset asynchronously between clock edges.
        step(); drive(1, 1, 1, 0, 0, 1, 7, 1, 0);
        step(); drive(1, 7, 1, 0, 1, 1, 8, 0, 0);
        expect_out("sat_hold1", 1, 0, 0, 0, 0, 0, 0, 15);
        step(); expect_out("sat_hold2", 1, 0, 0, 0, 0, 0, 0, 15);
        step(); #1;
        rst_n = 1'b0;
        expect_out("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive(1, 7, 1, 7, 1, 0, 0, 0, 0);
        step(); expect_out("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);

        step();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
